vga_draw_scheduler: RTL and testbench
=====================================

# vga_draw_scheduler

Owns the single 160x120 `vga_adapter` pixel port and shares it among up to `N_ENG` shape-drawing engines (fill-screen, circle, reuleaux, …). Accepts drawing commands through a valid/ready queue and runs one engine at a time via that engine's `start`/`done` handshake. While an engine runs, the block muxes its pixel stream onto the adapter and clips off-screen pixels. It sits between the board top level and the engines, replacing the hard-wired `start` logic.

## Interface
- `N_ENG`, 3, number of attached engines (2–8)
- `FIFO_DEPTH`, 4, command queue depth (power of two, ≥2)
- `TIMEOUT`, 65536, watchdog limit in cycles (used only with the macro)

- `clk`  in  1  system clock (CLOCK_50)
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  queue can accept; `= !full`
- `cmd_eng`  in  $clog2(N_ENG)  target engine index
- `cmd_colour`  in  3  colour passed to engine
- `cmd_cx` / `cmd_cy` / `cmd_diam`  in  8/7/8  centre x, centre y, diameter
- `eng_start`  out  N_ENG  one-hot start, held until done
- `eng_colour` / `eng_cx` / `eng_cy` / `eng_diam`  out  3/8/7/8  shared latched parameters
- `eng_done`  in  N_ENG  per-engine done
- `eng_x` / `eng_y` / `eng_col` / `eng_plot`  in  N_ENG×8 / N_ENG×7 / N_ENG×3 / N_ENG  packed per-engine pixel outputs
- `vga_x` / `vga_y` / `vga_colour` / `vga_plot`  out  8/7/3/1  to adapter
- `busy`  out  1  state ≠ IDLE or queue non-empty
- `err`  out  1  sticky; bad engine index or timeout
- `clip_cnt`  out  16  saturating count of clipped pixels

## Operation
- Queue: push on `cmd_valid && cmd_ready`. When full, a push is refused even if a pop happens in the same cycle. Order is FIFO.
- States: IDLE, RUN, RELEASE.
- IDLE: if queue non-empty, pop and latch `{eng, colour, cx, cy, diam}` into `eng_*`.
  - Index < N_ENG → RUN.
  - Index ≥ N_ENG → set `err`, stay IDLE, and drop the command.
- RUN: `eng_start[k]=1` for the latched k only. When `eng_done[k]=1` → RELEASE.
- RELEASE: all `eng_start=0` for exactly one cycle, which clears the engine's done → IDLE.
- Pixel mux, combinational:
  - In RUN, `vga_x/y/colour` come from engine k, and `vga_plot = eng_plot[k] && eng_x[k]<160 && eng_y[k]<120`.
  - Outside RUN, `vga_plot=0` and x/y/colour are 0.
  - Non-granted engines' plots are ignored.
- Clipping: if `eng_plot[k]` is high but the pixel is off-screen, `clip_cnt` increments; it saturates at 0xFFFF.
- `err` and `clip_cnt` clear only on reset.

## Timing
- Reset values: `cmd_ready=1`, `eng_start=0`, `eng_*` params 0, `vga_*`=0, `busy=0`, `err=0`, `clip_cnt=0`, queue empty, state IDLE.
- Latency: handshake at edge 0 → IDLE pops at edge 1 → `eng_start[k]` high after edge 1.
- Back-to-back: the next `eng_start` rises 2 cycles after `eng_done[k]` is seen (RELEASE cycle plus the IDLE pop).
- Reset mid-RUN: `eng_start` drops asynchronously and queued commands are discarded.
- `eng_done` of non-granted engines is ignored. `eng_done[k]` already high on RUN entry is accepted on the first RUN cycle.

## Configuration
- `VGA_SCHED_TIMEOUT_EN` defined:
  - A RUN-cycle counter runs; if it reaches `TIMEOUT` without done, go to RELEASE and set `err`.
  - The counter clears on RUN entry.
- `VGA_SCHED_TIMEOUT_EN` undefined: no counter; RUN waits indefinitely.

## Structure
- Package `vga_sched_pkg`:
  - `VGA_W=160`, `VGA_H=120`
  - `sched_state_t` enum
  - `draw_cmd_t` packed struct `{eng, colour, cx, cy, diam}`
- Sub-module `sched_cmd_fifo`:
  - Synchronous FIFO of `draw_cmd_t`, depth `FIFO_DEPTH`.
  - Provides full and empty flags, push and pop.
  - Uses the same async reset.

## Test plan
- Single command: eng=2, colour=3'b101, cx=80, cy=60, diam=40; engine stub raises done after 100 cycles.
  - Expect `eng_start=3'b100` from cycle 2 after the handshake, params on `eng_*`, stub pixels on `vga_*`.
  - Expect 1 RELEASE cycle, then `busy=0`.
- Queue full: push 5 commands with the engine stalled.
  - Expect `cmd_ready=0` after the 4th.
  - Expect all 4 accepted commands to run in order, each `eng_start` gap exactly 2 cycles after done.
- Clipping: stub emits (159,119), (160,10), (10,120), (255,127).
  - Expect only the first plotted and `clip_cnt=3`.
- Bad index: cmd_eng=3 with `N_ENG=3`.
  - Expect `err=1`, no `eng_start`, and the next valid command still runs.
- Non-granted isolation: engine 0 granted while engine 1 asserts plot and done.
  - Expect `vga_*` to follow only engine 0.
- Reset and timeout: assert `rst_n=0` mid-RUN.
  - Expect `eng_start=0` immediately and the queue empty.
- Timeout, with the macro and `TIMEOUT=50`: stub never raises done.
  - Expect `eng_start` to fall at cycle 50 of RUN, then `err=1`.

Source files
------------

// File: rtl/vga_draw_scheduler_pkg.sv
// Shared types and screen constants for the VGA draw scheduler.
package vga_sched_pkg;

    localparam logic [7:0]  VGA_W     = 8'd160;
    localparam logic [6:0]  VGA_H     = 7'd120;
    localparam int unsigned ENG_IDX_W = 3;  // wide enough for up to 8 engines

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StRelease
    } sched_state_t;

    typedef struct packed {
        logic [ENG_IDX_W-1:0] eng;
        logic [2:0]           colour;
        logic [7:0]           cx;
        logic [6:0]           cy;
        logic [7:0]           diam;
    } draw_cmd_t;

    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return (x < VGA_W) && (y < VGA_H);
    endfunction

endpackage

// File: rtl/vga_draw_scheduler_if.sv
// Command queue, engine and adapter signals of the draw scheduler.
interface vga_draw_scheduler_if #(
    parameter int unsigned N_ENG = 3
);
    localparam int unsigned EW = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [EW-1:0]      cmd_eng;
    logic [2:0]         cmd_colour;
    logic [7:0]         cmd_cx;
    logic [6:0]         cmd_cy;
    logic [7:0]         cmd_diam;

    logic [N_ENG-1:0]   eng_start;
    logic [2:0]         eng_colour;
    logic [7:0]         eng_cx;
    logic [6:0]         eng_cy;
    logic [7:0]         eng_diam;
    logic [N_ENG-1:0]   eng_done;
    logic [N_ENG*8-1:0] eng_x;
    logic [N_ENG*7-1:0] eng_y;
    logic [N_ENG*3-1:0] eng_col;
    logic [N_ENG-1:0]   eng_plot;

    logic [7:0]         vga_x;
    logic [6:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot;

    logic               busy;
    logic               err;
    logic [15:0]        clip_cnt;

    modport master (
        input  cmd_valid, cmd_eng, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
        input  eng_done, eng_x, eng_y, eng_col, eng_plot,
        output cmd_ready, eng_start, eng_colour, eng_cx, eng_cy, eng_diam,
        output vga_x, vga_y, vga_colour, vga_plot, busy, err, clip_cnt
    );

    modport slave (
        output cmd_valid, cmd_eng, cmd_colour, cmd_cx, cmd_cy, cmd_diam,
        output eng_done, eng_x, eng_y, eng_col, eng_plot,
        input  cmd_ready, eng_start, eng_colour, eng_cx, eng_cy, eng_diam,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, err, clip_cnt
    );

endinterface

// File: rtl/vga_draw_scheduler_cmd_fifo.sv
// Synchronous FIFO of draw commands; a push while full is refused even if a pop coincides.
module sched_cmd_fifo
    import vga_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  draw_cmd_t i_data,
    input  logic      i_pop,
    output draw_cmd_t o_data,
    output logic      o_full,
    output logic      o_empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    draw_cmd_t     r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Shares the 160x120 VGA pixel port among N_ENG engines, one command at a time.
// Optional RUN watchdog enabled by defining VGA_SCHED_TIMEOUT_EN.
module vga_draw_scheduler
    import vga_sched_pkg::*;
#(
    parameter int unsigned N_ENG      = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 65536
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_draw_scheduler_if.master bus
);
    sched_state_t     r_state;
    logic [N_ENG-1:0] r_start;
    logic [2:0]       r_colour;
    logic [7:0]       r_cx;
    logic [6:0]       r_cy;
    logic [7:0]       r_diam;
    logic             r_err;
    logic [15:0]      r_clip;
`ifdef VGA_SCHED_TIMEOUT_EN
    logic [31:0]      r_tmo;
`endif

    draw_cmd_t        w_cmd_in;
    draw_cmd_t        w_cmd_out;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [N_ENG-1:0] w_onehot;
    logic             w_done;
    logic [7:0]       w_sel_x;
    logic [6:0]       w_sel_y;
    logic [2:0]       w_sel_col;
    logic             w_sel_plot;
    logic             w_on;
    logic             w_clip;

    assign w_cmd_in = '{eng:    ENG_IDX_W'(bus.cmd_eng),
                        colour: bus.cmd_colour,
                        cx:     bus.cmd_cx,
                        cy:     bus.cmd_cy,
                        diam:   bus.cmd_diam};

    assign w_pop = (r_state == StIdle) && !w_empty;

    sched_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.cmd_valid),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_cmd_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_onehot = N_ENG'(1) << w_cmd_out.eng;
    // r_start is one-hot while running, so it doubles as the grant mask
    assign w_done   = |(bus.eng_done & r_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_start  <= '0;
            r_colour <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
            r_diam   <= '0;
            r_err    <= 1'b0;
`ifdef VGA_SCHED_TIMEOUT_EN
            r_tmo    <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_colour <= w_cmd_out.colour;
                        r_cx     <= w_cmd_out.cx;
                        r_cy     <= w_cmd_out.cy;
                        r_diam   <= w_cmd_out.diam;
                        if (32'(w_cmd_out.eng) < N_ENG) begin
                            r_start <= w_onehot;
                            r_state <= StRun;
`ifdef VGA_SCHED_TIMEOUT_EN
                            r_tmo   <= '0;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_done) begin
                        r_start <= '0;
                        r_state <= StRelease;
                    end
`ifdef VGA_SCHED_TIMEOUT_EN
                    else if (r_tmo == TIMEOUT - 1) begin
                        r_start <= '0;
                        r_state <= StRelease;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
`endif
                end
                StRelease: r_state <= StIdle;
                default:   r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        w_sel_x    = '0;
        w_sel_y    = '0;
        w_sel_col  = '0;
        w_sel_plot = 1'b0;
        if (r_state == StRun) begin
            for (int unsigned i = 0; i < N_ENG; i++) begin
                if (r_start[i]) begin
                    w_sel_x    = bus.eng_x[i*8 +: 8];
                    w_sel_y    = bus.eng_y[i*7 +: 7];
                    w_sel_col  = bus.eng_col[i*3 +: 3];
                    w_sel_plot = bus.eng_plot[i];
                end
            end
        end
    end

    assign w_on   = on_screen(w_sel_x, w_sel_y);
    assign w_clip = w_sel_plot && !w_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= '0;
        end else if (w_clip && (r_clip != 16'hFFFF)) begin
            r_clip <= r_clip + 16'd1;
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.eng_start  = r_start;
    assign bus.eng_colour = r_colour;
    assign bus.eng_cx     = r_cx;
    assign bus.eng_cy     = r_cy;
    assign bus.eng_diam   = r_diam;
    assign bus.vga_x      = w_sel_x;
    assign bus.vga_y      = w_sel_y;
    assign bus.vga_colour = w_sel_col;
    assign bus.vga_plot   = w_sel_plot && w_on;
    assign bus.busy       = (r_state != StIdle) || !w_empty;
    assign bus.err        = r_err;
    assign bus.clip_cnt   = r_clip;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed self-checking bench for vga_draw_scheduler (N_ENG=3, FIFO_DEPTH=4, TIMEOUT=50).
module tb_vga_draw_scheduler;

    localparam int unsigned N_ENG = 3;
`ifdef VGA_SCHED_TIMEOUT_EN
    localparam int RUN_LEN = 30;
`else
    localparam int RUN_LEN = 100;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    vga_draw_scheduler_if #(.N_ENG(N_ENG)) bus ();

    vga_draw_scheduler #(
        .N_ENG      (N_ENG),
        .FIFO_DEPTH (4),
        .TIMEOUT    (50)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] eng, input logic [7:0] cx);
        bus.cmd_valid  = 1'b1;
        bus.cmd_eng    = eng;
        bus.cmd_colour = 3'd1;
        bus.cmd_cx     = cx;
        bus.cmd_cy     = 7'd10;
        bus.cmd_diam   = 8'd20;
        step();
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic set_pix(input int k, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic p);
        bus.eng_x[k*8 +: 8] = x;
        bus.eng_y[k*7 +: 7] = y;
        bus.eng_col[k*3 +: 3] = c;
        bus.eng_plot[k] = p;
    endtask

    // Pulse done for engine k and check the RELEASE and IDLE cycles
    task automatic complete(input int k);
        bus.eng_done[k] = 1'b1;
        step();
        bus.eng_done[k] = 1'b0;
        check("release_start", 32'(bus.eng_start), 32'h0);
        check("release_busy", 32'(bus.busy), 32'h1);
        step();
        check("idle_start", 32'(bus.eng_start), 32'h0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_eng    = '0;
        bus.cmd_colour = '0;
        bus.cmd_cx     = '0;
        bus.cmd_cy     = '0;
        bus.cmd_diam   = '0;
        bus.eng_done   = '0;
        bus.eng_x      = '0;
        bus.eng_y      = '0;
        bus.eng_col    = '0;
        bus.eng_plot   = '0;
        repeat (3) step();
        check("rst_ready", 32'(bus.cmd_ready), 32'h1);
        check("rst_start", 32'(bus.eng_start), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_clip", 32'(bus.clip_cnt), 32'h0);
        check("rst_cx", 32'(bus.eng_cx), 32'h0);
        rst_n = 1'b1;
        step();

        // Single command
        bus.cmd_valid  = 1'b1;
        bus.cmd_eng    = 2'd2;
        bus.cmd_colour = 3'b101;
        bus.cmd_cx     = 8'd80;
        bus.cmd_cy     = 7'd60;
        bus.cmd_diam   = 8'd40;
        step();
        bus.cmd_valid = 1'b0;
        check("t1_start_e0", 32'(bus.eng_start), 32'h0);
        check("t1_busy_e0", 32'(bus.busy), 32'h1);
        step();
        check("t1_start_e1", 32'(bus.eng_start), 32'h4);
        check("t1_colour", 32'(bus.eng_colour), 32'h5);
        check("t1_cx", 32'(bus.eng_cx), 32'd80);
        check("t1_cy", 32'(bus.eng_cy), 32'd60);
        check("t1_diam", 32'(bus.eng_diam), 32'd40);
        set_pix(2, 8'd50, 7'd30, 3'd6, 1'b1);
        #1;
        check("t1_vga_x", 32'(bus.vga_x), 32'd50);
        check("t1_vga_y", 32'(bus.vga_y), 32'd30);
        check("t1_vga_col", 32'(bus.vga_colour), 32'd6);
        check("t1_vga_plot", 32'(bus.vga_plot), 32'h1);
        repeat (RUN_LEN - 2) step();
        check("t1_still_run", 32'(bus.eng_start), 32'h4);
        complete(2);
        set_pix(2, 8'd0, 7'd0, 3'd0, 1'b0);
        check("t1_idle_busy", 32'(bus.busy), 32'h0);

        // Queue full: one command running, then five offered
        push(2'd0, 8'd1);
        step();
        check("t2_a_start", 32'(bus.eng_start), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("t2_ready_pre", 32'(bus.cmd_ready), 32'h1);
            push(2'(i % 3 + 1 > 2 ? 0 : i % 3 + 1), 8'(i + 2));
        end
        check("t2_ready_full", 32'(bus.cmd_ready), 32'h0);
        push(2'd2, 8'd6);
        check("t2_ready_still", 32'(bus.cmd_ready), 32'h0);
        complete(0);
        // Expected order: engines 1,2,0,1 with cx 2..5
        for (int i = 0; i < 4; i++) begin
            int unsigned k;
            k = (i == 2) ? 0 : ((i == 3) ? 1 : i + 1);
            step();
            check("t2_start", 32'(bus.eng_start), 32'(1 << k));
            check("t2_cx", 32'(bus.eng_cx), 32'(i + 2));
            step();
            complete(int'(k));
        end
        step();
        check("t2_refused_start", 32'(bus.eng_start), 32'h0);
        check("t2_refused_busy", 32'(bus.busy), 32'h0);

        // Clipping
        push(2'd1, 8'd9);
        step();
        check("t3_start", 32'(bus.eng_start), 32'h2);
        set_pix(1, 8'd159, 7'd119, 3'd2, 1'b1);
        #1;
        check("t3_p0_plot", 32'(bus.vga_plot), 32'h1);
        check("t3_p0_x", 32'(bus.vga_x), 32'd159);
        step();
        set_pix(1, 8'd160, 7'd10, 3'd2, 1'b1);
        #1;
        check("t3_p1_plot", 32'(bus.vga_plot), 32'h0);
        step();
        set_pix(1, 8'd10, 7'd120, 3'd2, 1'b1);
        #1;
        check("t3_p2_plot", 32'(bus.vga_plot), 32'h0);
        step();
        set_pix(1, 8'd255, 7'd127, 3'd2, 1'b1);
        #1;
        check("t3_p3_plot", 32'(bus.vga_plot), 32'h0);
        step();
        set_pix(1, 8'd0, 7'd0, 3'd0, 1'b0);
        check("t3_clip", 32'(bus.clip_cnt), 32'd3);
        complete(1);

        // Bad index, then a valid command still runs
        push(2'd3, 8'd7);
        step();
        check("t4_err", 32'(bus.err), 32'h1);
        check("t4_start", 32'(bus.eng_start), 32'h0);
        check("t4_busy", 32'(bus.busy), 32'h0);
        push(2'd0, 8'd8);
        step();
        check("t4_next_start", 32'(bus.eng_start), 32'h1);
        check("t4_next_cx", 32'(bus.eng_cx), 32'd8);

        // Non-granted engine 1 plots off-screen and raises done
        set_pix(0, 8'd7, 7'd8, 3'd3, 1'b0);
        set_pix(1, 8'd200, 7'd20, 3'd2, 1'b1);
        bus.eng_done[1] = 1'b1;
        #1;
        check("t5_plot", 32'(bus.vga_plot), 32'h0);
        check("t5_x", 32'(bus.vga_x), 32'd7);
        check("t5_y", 32'(bus.vga_y), 32'd8);
        check("t5_col", 32'(bus.vga_colour), 32'd3);
        step();
        check("t5_start_kept", 32'(bus.eng_start), 32'h1);
        check("t5_clip_kept", 32'(bus.clip_cnt), 32'd3);
        bus.eng_done[1] = 1'b0;
        set_pix(1, 8'd0, 7'd0, 3'd0, 1'b0);
        set_pix(0, 8'd7, 7'd8, 3'd3, 1'b1);
        #1;
        check("t5_own_plot", 32'(bus.vga_plot), 32'h1);
        set_pix(0, 8'd0, 7'd0, 3'd0, 1'b0);
        complete(0);

        // Done already high on RUN entry is taken in the first RUN cycle
        bus.eng_done[2] = 1'b1;
        push(2'd2, 8'd11);
        step();
        check("t6_start", 32'(bus.eng_start), 32'h4);
        step();
        bus.eng_done[2] = 1'b0;
        check("t6_release", 32'(bus.eng_start), 32'h0);
        step();

        // Reset mid-RUN with queued commands
        push(2'd1, 8'd12);
        step();
        push(2'd2, 8'd13);
        push(2'd0, 8'd14);
        check("t7_run", 32'(bus.eng_start), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_start", 32'(bus.eng_start), 32'h0);
        check("t7_busy", 32'(bus.busy), 32'h0);
        check("t7_err_clr", 32'(bus.err), 32'h0);
        check("t7_clip_clr", 32'(bus.clip_cnt), 32'h0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("t7_post_start", 32'(bus.eng_start), 32'h0);
        check("t7_post_busy", 32'(bus.busy), 32'h0);

`ifdef VGA_SCHED_TIMEOUT_EN
        // Watchdog: engine never finishes
        begin
            int n;
            n = 0;
            push(2'd2, 8'd15);
            step();
            check("t8_start", 32'(bus.eng_start), 32'h4);
            while (bus.eng_start != '0 && n < 200) begin
                step();
                n++;
            end
            check("t8_cycles", 32'(n), 32'd50);
            check("t8_err", 32'(bus.err), 32'h1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
